// File: rtl/dcache_s2.sv
// dcache_s2 -- second stage of the 2-way, 64-set, 32-byte-line data cache.
//
// Compares the tags and valid bits registered by stage 1 against the
// physical address, returns load data on a hit with no added latency, and
// runs the miss / uncached / write-through state machine towards the AXI
// bridge. Cached stores are write-through and no-write-allocate; a store
// that hits also patches one word of the hit way through hit_wen_o.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   s2_vaddr_i, s2_paddr_i      registered virtual / physical address
//   tagv_w0_i, tagv_w1_i        way tags;  valid0_i, valid1_i way valid bits
//   cache_rreq_i, cache_wreq_i,
//   uc_rreq_i, uc_wreq_i        request class (one-hot or idle)
//   data_way0_i, data_way1_i    selected bank word of each way
//   bus_wen_i, bus_wdata_i      store byte enables and data
//   rend_i, rdata_i             AXI read done + line / word data
//   wend_i                      AXI write done
//   rd_req_o, rd_line_o,
//   rd_addr_o                   read request towards the bridge
//   wr_req_o, wr_addr_o,
//   wr_data_o, wr_strb_o        write request towards the bridge
//   hit1_o, hit2_o              way0 / way1 hit (way0 wins when both hit)
//   s2rreq_o, s2wreq_o          cached read / write present
//   status_o                    current FSM state
//   hit_wen_o, hit_way_o,
//   hit_wdata_o                 write-hit word update for stage 1
//   dcache_stall_o              stall to stage 1 and the pipeline
//   rdata_o, rdata_valid_o      load data and its valid strobe

module dcache_s2 #(
  parameter int TAG_W  = 21,
  parameter int LINE_W = 256,
  parameter int ST_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s2_vaddr_i,
  input  logic [31:0]       s2_paddr_i,
  input  logic [TAG_W-1:0]  tagv_w0_i,
  input  logic [TAG_W-1:0]  tagv_w1_i,
  input  logic              valid0_i,
  input  logic              valid1_i,
  input  logic              cache_rreq_i,
  input  logic              cache_wreq_i,
  input  logic              uc_rreq_i,
  input  logic              uc_wreq_i,
  input  logic [31:0]       data_way0_i,
  input  logic [31:0]       data_way1_i,
  input  logic [3:0]        bus_wen_i,
  input  logic [31:0]       bus_wdata_i,
  input  logic              rend_i,
  input  logic [LINE_W-1:0] rdata_i,
  input  logic              wend_i,
  output logic              rd_req_o,
  output logic              rd_line_o,
  output logic [31:0]       rd_addr_o,
  output logic              wr_req_o,
  output logic [31:0]       wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic [3:0]        wr_strb_o,
  output logic              hit1_o,
  output logic              hit2_o,
  output logic              s2rreq_o,
  output logic              s2wreq_o,
  output logic [ST_W-1:0]   status_o,
  output logic              hit_wen_o,
  output logic              hit_way_o,
  output logic [31:0]       hit_wdata_o,
  output logic              dcache_stall_o,
  output logic [31:0]       rdata_o,
  output logic              rdata_valid_o
);

  typedef enum logic [ST_W-1:0] {
    IDLE    = 2'd0,
    CA_READ = 2'd1,
    UC_READ = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------------
  // Tag compare
  // ---------------------------------------------------------------------------
  logic        hit_w0, hit_w1, cache_req, cache_hit;
  logic [31:0] hit_word;
  logic [2:0]  word_sel;
  logic [31:0] line_word;

  assign hit_w0    = valid0_i & (tagv_w0_i == s2_paddr_i[31:11]);
  assign hit_w1    = valid1_i & (tagv_w1_i == s2_paddr_i[31:11]);
  assign cache_req = cache_rreq_i | cache_wreq_i;
  assign cache_hit = hit_w0 | hit_w1;

  assign hit1_o   = hit_w0 & cache_req;
  assign hit2_o   = hit_w1 & ~hit_w0 & cache_req;
  assign s2rreq_o = cache_rreq_i;
  assign s2wreq_o = cache_wreq_i;

  // Way 0 has priority when both ways hit.
  assign hit_word  = hit_w0 ? data_way0_i : data_way1_i;
  assign word_sel  = s2_paddr_i[4:2];
  assign line_word = rdata_i[{word_sel, 5'd0} +: 32];

  // Byte-merge the store into the hit word; only consumed when hit_wen_o=1.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      hit_wdata_o[8*k +: 8] = bus_wen_i[k] ? bus_wdata_i[8*k +: 8]
                                           : hit_word[8*k +: 8];
    end
  end
  assign hit_way_o = ~hit_w0;

  // The virtual address only indexed the RAMs in stage 1; the two paddr
  // low bits are meaningful only for the uncached read address.
  logic unused_vaddr;
  assign unused_vaddr = ^s2_vaddr_i;

  // ---------------------------------------------------------------------------
  // State register -- the only storage in this stage. Address and data are
  // held by stage 1 for as long as dcache_stall_o is high.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  logic done;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    done           = 1'b0;
    rd_req_o       = 1'b0;
    rd_line_o      = 1'b0;
    rd_addr_o      = 32'd0;
    wr_req_o       = 1'b0;
    wr_addr_o      = 32'd0;
    wr_data_o      = 32'd0;
    wr_strb_o      = 4'd0;
    hit_wen_o      = 1'b0;
    dcache_stall_o = 1'b0;
    rdata_o        = 32'd0;
    rdata_valid_o  = 1'b0;

    unique case (state)
      IDLE: begin
        if (cache_rreq_i && cache_hit) begin
          rdata_o       = hit_word;
          rdata_valid_o = 1'b1;
        end else if (cache_rreq_i) begin
          dcache_stall_o = 1'b1;
          state_nxt      = CA_READ;
        end else if (uc_rreq_i) begin
          dcache_stall_o = 1'b1;
          state_nxt      = UC_READ;
        end else if (cache_wreq_i || uc_wreq_i) begin
          dcache_stall_o = 1'b1;
          hit_wen_o      = cache_wreq_i & cache_hit;
          state_nxt      = WRITE;
        end
      end

      CA_READ: begin
        done      = rend_i;
        rd_req_o  = 1'b1;
        rd_line_o = 1'b1;
        rd_addr_o = {s2_paddr_i[31:5], 5'd0};
        if (rend_i) begin
          rdata_o       = line_word;
          rdata_valid_o = 1'b1;
          state_nxt     = IDLE;
        end
      end

      UC_READ: begin
        done      = rend_i;
        rd_req_o  = 1'b1;
        rd_addr_o = s2_paddr_i;
        if (rend_i) begin
          rdata_o       = rdata_i[31:0];
          rdata_valid_o = 1'b1;
          state_nxt     = IDLE;
        end
      end

      WRITE: begin
        done      = wend_i;
        wr_req_o  = 1'b1;
        wr_addr_o = {s2_paddr_i[31:2], 2'b00};
        wr_data_o = bus_wdata_i;
        wr_strb_o = bus_wen_i;
        if (wend_i) state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) dcache_stall_o = ~done;

    // While reset is asserted the bridge and stage 1 must see no activity,
    // even in the cycle before the state register has returned to IDLE.
    if (!rst_n) begin
      rd_req_o       = 1'b0;
      wr_req_o       = 1'b0;
      hit_wen_o      = 1'b0;
      dcache_stall_o = 1'b0;
      rdata_valid_o  = 1'b0;
    end
  end

  assign status_o = state;

endmodule
